// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } arb_state_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_ADDR_LIMIT = 1024;
    localparam int DEF_MEM_LAT    = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick; the pointer remembers the last granted port.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;

    assign grant_o[PORT_F] = req_i[PORT_F] & (~req_i[PORT_D] | (ptr_q == PORT_D));
    assign grant_o[PORT_D] = req_i[PORT_D] & (~req_i[PORT_F] | (ptr_q == PORT_F));

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= PORT_D;
        end else if (advance_i && (grant_o != 2'b00)) begin
            ptr_q <= grant_o[PORT_D] ? PORT_D : PORT_F;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a fetch and a data requester.
// Optional grant/error statistics counters: MEM_PORT_ARBITER_STATS_EN.
//
// state | meaning
// IDLE  | arbitrating; grant pulses combinationally, payload latched at edge
// ISSUE | m_en high for one cycle with the latched access
// WAIT  | counting down memory latency; m_rdata sampled when counter is 0
// RESP  | owner's valid pulse with read data (writes keep old rdata)
// ERR   | owner's valid pulse with err=1; memory never touched
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_LIMIT = DEF_ADDR_LIMIT,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int AW         = $clog2(ADDR_LIMIT)
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          f_req_i,
    input  logic [63:0]   f_addr_i,
    output logic          f_gnt_o,
    output logic          f_valid_o,
    output logic [63:0]   f_rdata_o,
    output logic          f_err_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [63:0]   d_addr_i,
    input  logic [63:0]   d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_valid_o,
    output logic [63:0]   d_rdata_o,
    output logic          d_err_o,
    output logic          m_en_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [63:0]   m_wdata_o,
    input  logic [63:0]   m_rdata_i,
    output logic          busy_o
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [15:0]   f_gnt_cnt_o,
    output logic [15:0]   d_gnt_cnt_o,
    output logic [15:0]   err_cnt_o
`endif
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    arb_state_e    state_q;
    logic          ready_q;
    logic          port_q;
    logic          we_q;
    logic [3:0]    cnt_q;
    logic          m_en_q, m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [63:0]   m_wdata_q;
    logic          f_valid_q, d_valid_q;
    logic          f_err_q, d_err_q;
    logic [63:0]   f_rdata_q, d_rdata_q;

    logic [1:0]    arb_req, arb_gnt;
    logic          idle;
    logic          sel_d;
    logic [63:0]   sel_addr;
    logic          sel_we;
    logic          sel_oor;

    // ready_q keeps grants low while in reset and for the first edge after it
    assign idle    = (state_q == IDLE) && ready_q;
    assign arb_req = {d_req_i, f_req_i} & {2{idle}};

    rr_arb2 u_rr_arb2 (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .req_i     (arb_req),
        .advance_i (idle),
        .grant_o   (arb_gnt)
    );

    assign f_gnt_o  = arb_gnt[PORT_F];
    assign d_gnt_o  = arb_gnt[PORT_D];
    assign sel_d    = arb_gnt[PORT_D];
    assign sel_addr = sel_d ? d_addr_i : f_addr_i;
    assign sel_we   = sel_d & d_we_i;
    assign sel_oor  = (sel_addr >= 64'(ADDR_LIMIT));

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            port_q    <= PORT_F;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            f_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            f_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            ready_q   <= 1'b1;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            f_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        port_q    <= sel_d;
                        we_q      <= sel_we;
                        m_addr_q  <= sel_addr[AW-1:0];
                        m_wdata_q <= sel_d ? d_wdata_i : 64'd0;
                        if (sel_oor) begin
                            state_q <= ERR;
                            if (sel_d) begin
                                d_valid_q <= 1'b1;
                                d_err_q   <= 1'b1;
                            end else begin
                                f_valid_q <= 1'b1;
                                f_err_q   <= 1'b1;
                            end
                        end else begin
                            state_q <= ISSUE;
                            m_en_q  <= 1'b1;
                            m_we_q  <= sel_we;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT_M1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        if (port_q == PORT_D) begin
                            d_valid_q <= 1'b1;
                            d_err_q   <= 1'b0;
                            if (!we_q) begin
                                d_rdata_q <= m_rdata_i;
                            end
                        end else begin
                            f_valid_q <= 1'b1;
                            f_err_q   <= 1'b0;
                            f_rdata_q <= m_rdata_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign f_valid_o = f_valid_q;
    assign f_rdata_o = f_rdata_q;
    assign f_err_o   = f_err_q;
    assign d_valid_o = d_valid_q;
    assign d_rdata_o = d_rdata_q;
    assign d_err_o   = d_err_q;
    assign m_en_o    = m_en_q;
    assign m_we_o    = m_we_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign busy_o    = (state_q != IDLE);

`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0] f_gnt_cnt_q, d_gnt_cnt_q, err_cnt_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            f_gnt_cnt_q <= '0;
            d_gnt_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (f_gnt_o && (f_gnt_cnt_q != 16'hFFFF)) f_gnt_cnt_q <= f_gnt_cnt_q + 16'd1;
            if (d_gnt_o && (d_gnt_cnt_q != 16'hFFFF)) d_gnt_cnt_q <= d_gnt_cnt_q + 16'd1;
            if ((arb_gnt != 2'b00) && sel_oor && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign f_gnt_cnt_o = f_gnt_cnt_q;
    assign d_gnt_cnt_o = d_gnt_cnt_q;
    assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-accurate memory model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int LAT_OK  = MEM_LAT + 2;

    typedef struct {
        logic [63:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_req, d_req, d_we;
    logic [63:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_valid, f_err, d_gnt, d_valid, d_err;
    logic [63:0] f_rdata, d_rdata;
    logic        m_en, m_we, busy;
    logic [9:0]  m_addr;
    logic [63:0] m_wdata, m_rdata;
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0] f_gnt_cnt, d_gnt_cnt, err_cnt;
`endif

    mem_port_arbiter dut (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .f_req_i   (f_req),
        .f_addr_i  (f_addr),
        .f_gnt_o   (f_gnt),
        .f_valid_o (f_valid),
        .f_rdata_o (f_rdata),
        .f_err_o   (f_err),
        .d_req_i   (d_req),
        .d_we_i    (d_we),
        .d_addr_i  (d_addr),
        .d_wdata_i (d_wdata),
        .d_gnt_o   (d_gnt),
        .d_valid_o (d_valid),
        .d_rdata_o (d_rdata),
        .d_err_o   (d_err),
        .m_en_o    (m_en),
        .m_we_o    (m_we),
        .m_addr_o  (m_addr),
        .m_wdata_o (m_wdata),
        .m_rdata_i (m_rdata),
        .busy_o    (busy)
`ifdef MEM_PORT_ARBITER_STATS_EN
        ,
        .f_gnt_cnt_o (f_gnt_cnt),
        .d_gnt_cnt_o (d_gnt_cnt),
        .err_cnt_o   (err_cnt)
`endif
    );

    always #5 clock = ~clock;

    // memory model: data appears MEM_LAT cycles after the m_en cycle, junk otherwise
    logic [63:0] mem [0:1023];
    logic [63:0] rd_pipe [0:MEM_LAT-1];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [63:0] bd_data = '0;

    always @(posedge clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (m_en && m_we) mem[m_addr] <= m_wdata;
        rd_pipe[0] <= (m_en && !m_we) ? mem[m_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign m_rdata = rd_pipe[MEM_LAT-1];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int f_gnt_cyc = 0;
    int d_gnt_cyc = 0;
    int men_count = 0;
    logic exp_gnt [$];
    exp_t f_exp [$];
    exp_t d_exp [$];
    logic [63:0] f_last = '0;
    logic [63:0] d_last = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a gnt, m_en or valid
    always @(negedge clock) begin
        if (reset_n) begin
            exp_t e;
            if (f_gnt || d_gnt) begin
                check("gnt_excl", 64'(f_gnt & d_gnt), 64'd0);
                if (exp_gnt.size() == 0) fail("gnt_unexpected");
                else check("gnt_port", 64'(d_gnt), 64'(exp_gnt.pop_front()));
                last_gnt_cyc = cyc;
                if (f_gnt) f_gnt_cyc = cyc;
                if (d_gnt) d_gnt_cyc = cyc;
            end
            if (m_en) begin
                men_count++;
                check("m_en_lat", 64'(cyc - last_gnt_cyc), 64'd1);
            end
            if (f_valid || d_valid) check("valid_excl", 64'(f_valid & d_valid), 64'd0);
            if (f_valid) begin
                if (f_exp.size() == 0) fail("f_valid_unexpected");
                else begin
                    e = f_exp.pop_front();
                    check("f_rdata", f_rdata, e.rd);
                    check("f_err", 64'(f_err), 64'(e.err));
                    check("f_lat", 64'(cyc - f_gnt_cyc), 64'(e.lat));
                end
            end
            if (d_valid) begin
                if (d_exp.size() == 0) fail("d_valid_unexpected");
                else begin
                    e = d_exp.pop_front();
                    check("d_rdata", d_rdata, e.rd);
                    check("d_err", 64'(d_err), 64'(e.err));
                    check("d_lat", 64'(cyc - d_gnt_cyc), 64'(e.lat));
                end
            end
        end
    end

    task automatic bd_write(input logic [9:0] a, input logic [63:0] v);
        @(negedge clock);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        @(posedge clock); #1;
        bd_we = 1'b0;
    endtask

    task automatic reset_check();
        check("rst_f_gnt", 64'(f_gnt), 64'd0);
        check("rst_d_gnt", 64'(d_gnt), 64'd0);
        check("rst_f_valid", 64'(f_valid), 64'd0);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_f_rdata", f_rdata, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        check("rst_f_err", 64'(f_err), 64'd0);
        check("rst_d_err", 64'(d_err), 64'd0);
        check("rst_m_en", 64'(m_en), 64'd0);
        check("rst_m_we", 64'(m_we), 64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_m_wdata", m_wdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    task automatic d_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [63:0] mem_val, input logic err);
        exp_t e;
        bit   got;
        e.rd  = (we || err) ? d_last : mem_val;
        e.err = err;
        e.lat = err ? 1 : LAT_OK;
        d_last = e.rd;
        exp_gnt.push_back(1'b1);
        d_exp.push_back(e);
        @(posedge clock); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (d_gnt) begin got = 1; break; end
        end
        if (!got) fail("d_gnt_timeout");
        @(posedge clock); #1;
        d_req = 1'b0; d_we = 1'b1; d_addr = '1; d_wdata = 64'hFFFF_EEEE_DDDD_CCCC;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (d_valid) begin got = 1; break; end
        end
        if (!got) fail("d_valid_timeout");
    endtask

    task automatic f_read(input logic [63:0] addr, input logic [63:0] mem_val, input logic err);
        exp_t e;
        bit   got;
        e.rd  = err ? f_last : mem_val;
        e.err = err;
        e.lat = err ? 1 : LAT_OK;
        f_last = e.rd;
        exp_gnt.push_back(1'b0);
        f_exp.push_back(e);
        @(posedge clock); #1;
        f_req = 1'b1; f_addr = addr;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (f_gnt) begin got = 1; break; end
        end
        if (!got) fail("f_gnt_timeout");
        @(posedge clock); #1;
        f_req = 1'b0; f_addr = '1;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (f_valid) begin got = 1; break; end
        end
        if (!got) fail("f_valid_timeout");
    endtask

    initial begin
        int  men_snap;
        int  ngnt;
        bit  got;
        exp_t e;
        reset_n = 1'b0;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        bd_write(10'd0, 64'h0000_0000_0000_0A0A);
        bd_write(10'd1, 64'h0000_0000_0000_1111);
        bd_write(10'd2, 64'h0000_0000_0000_2222);
        bd_write(10'd3, 64'h0000_0000_0000_3333);
        bd_write(10'd5, 64'h0000_0000_DEAD_BEEF);
        bd_write(10'd1023, 64'h0);
        reset_check();
        @(negedge clock); reset_n = 1'b1;

        // single D read, then write/read at the top legal address
        d_access(1'b0, 64'd5, 64'd0, 64'h0000_0000_DEAD_BEEF, 1'b0);
        d_access(1'b1, 64'd1023, 64'h1234, 64'd0, 1'b0);
        f_read(64'd1023, 64'h1234, 1'b0);
        check("mem_1023", mem[1023], 64'h1234);

        // out-of-range accesses never reach memory
        men_snap = men_count;
        d_access(1'b0, 64'd1024, 64'd0, 64'd0, 1'b1);
        d_access(1'b0, 64'h1_0000_0005, 64'd0, 64'd0, 1'b1);
        d_access(1'b1, 64'd1024, 64'h5555, 64'd0, 1'b1);
        f_read(64'h8000_0000_0000_0000, 64'd0, 1'b1);
        check("err_no_m_en", 64'(men_count), 64'(men_snap));
        check("mem_0_kept", mem[0], 64'h0A0A);
        check("mem_5_kept", mem[5], 64'h0000_0000_DEAD_BEEF);

        // contention from reset: expect F,D,F,D
        @(negedge clock); reset_n = 1'b0;
        f_req = 1'b1; f_addr = 64'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'd2; d_wdata = '0;
        @(negedge clock);
        reset_check();
        f_last = '0; d_last = '0;
        e.err = 1'b0; e.lat = LAT_OK;
        for (int k = 0; k < 2; k++) begin
            exp_gnt.push_back(1'b0);
            exp_gnt.push_back(1'b1);
            e.rd = 64'h1111; f_exp.push_back(e);
            e.rd = 64'h2222; d_exp.push_back(e);
        end
        reset_n = 1'b1;
        ngnt = 0;
        got = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (f_gnt || d_gnt) ngnt++;
            if (ngnt == 4) begin got = 1; break; end
        end
        if (!got) fail("contention_gnt_timeout");
        @(posedge clock); #1;
        f_req = 1'b0; d_req = 1'b0;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (d_valid) begin got = 1; break; end
        end
        if (!got) fail("contention_valid_timeout");
        f_last = 64'h1111; d_last = 64'h2222;

        // async reset while waiting on memory: transaction is dropped
        exp_gnt.push_back(1'b0);
        @(posedge clock); #1;
        f_req = 1'b1; f_addr = 64'd3;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (f_gnt) begin got = 1; break; end
        end
        if (!got) fail("rstwait_gnt_timeout");
        @(posedge clock); #1;
        f_req = 1'b0;
        @(posedge clock); #1;
        check("busy_in_wait", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_m_en", 64'(m_en), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_f_valid", 64'(f_valid), 64'd0);
        check("rst_async_d_valid", 64'(d_valid), 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        f_last = '0; d_last = '0;
        f_read(64'd0, 64'h0A0A, 1'b0);

`ifdef MEM_PORT_ARBITER_STATS_EN
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock);
        check("stat_rst_f", 64'(f_gnt_cnt), 64'd0);
        check("stat_rst_err", 64'(err_cnt), 64'd0);
        reset_n = 1'b1;
        f_last = '0; d_last = '0;
        f_read(64'd1, 64'h1111, 1'b0);
        f_read(64'd1, 64'h1111, 1'b0);
        f_read(64'd1, 64'h1111, 1'b0);
        d_access(1'b0, 64'd2, 64'd0, 64'h2222, 1'b0);
        d_access(1'b0, 64'd1024, 64'd0, 64'd0, 1'b1);
        check("stat_f_gnt", 64'(f_gnt_cnt), 64'd3);
        check("stat_d_gnt", 64'(d_gnt_cnt), 64'd2);
        check("stat_err", 64'(err_cnt), 64'd1);
`endif

        repeat (4) @(negedge clock);
        check("leftover_gnt", 64'(exp_gnt.size()), 64'd0);
        check("leftover_f", 64'(f_exp.size()), 64'd0);
        check("leftover_d", 64'(d_exp.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port 64-bit data memory array (1024 words) between two requesters:
  - fetch port (F): read-only instruction/operand reads.
  - data port (D): rmmovq/mrmovq/pushq/popq/call/ret accesses.
- Applies round-robin arbitration, fixed-latency access sequencing and out-of-range checking; raises a per-port error instead of touching memory.
- Sits between the pipelined core's fetch/memory stages and the memory array.

Parameters:
- ADDR_LIMIT, 1024, number of valid words; addr >= ADDR_LIMIT is an error.
- MEM_LAT, 2, cycles from m_en to valid m_rdata (legal range 1..15).
- AW, 10, memory-side address width (clog2 of ADDR_LIMIT).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request.
- f_addr  in  64  fetch word address.
- f_gnt  out  1  one-cycle grant pulse; payload sampled this cycle.
- f_valid  out  1  one-cycle completion pulse.
- f_rdata  out  64  read data, valid with f_valid.
- f_err  out  1  out-of-range flag, valid with f_valid.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  64  data word address.
- d_wdata  in  64  write data.
- d_gnt  out  1  grant pulse.
- d_valid  out  1  completion pulse.
- d_rdata  out  64  read data.
- d_err  out  1  out-of-range flag.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  64  memory write data.
- m_rdata  in  64  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; rr pointer = D (so F wins the first tie); latched payload cleared.
- Reset mid-access: m_en drops immediately; the transaction is lost; no valid pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - Only one request: grant it.
  - Both requesting: grant the port not equal to the rr pointer, then set the pointer to the granted port.
  - Grant cycle T: gnt pulses; addr/we/wdata/port id are latched.
  - Out of range (full 64-bit compare, addr >= ADDR_LIMIT): go to ERR.
  - Otherwise: go to ISSUE.
  - F is always a read; f side has no we.
- ISSUE (T+1):
  - m_en=1 for exactly one cycle; m_addr = addr[AW-1:0]; m_we = latched we; m_wdata = latched wdata.
  - Load counter with MEM_LAT-1.
  - MEM_LAT=1: go directly to RESP sampling; otherwise go to WAIT.
- WAIT: decrement the counter; at 0, sample m_rdata at cycle T+1+MEM_LAT.
- RESP (T+2+MEM_LAT):
  - Owner's valid=1 for one cycle.
  - Reads: rdata = sampled word.
  - Writes: rdata holds its previous value.
  - err=0. Next state IDLE.
- ERR (T+1): owner's valid=1 and err=1; rdata unchanged; no m_en. Next state IDLE.
- rdata/err are held registers; they change only on the owner's valid.
- Grants happen only in IDLE. Back-to-back throughput is one access per MEM_LAT+3 cycles (errors: 2 cycles).
- Handshake:
  - A requester holds req until it sees gnt.
  - req still high in the cycle after gnt is a new request.
  - Payload is ignored outside the grant cycle.
  - gnt and valid are never asserted to both ports in the same cycle.
- Address 1023 is legal; 1024 and any nonzero upper bits are errors.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined: adds outputs f_gnt_cnt[15:0], d_gnt_cnt[15:0] and err_cnt[15:0].
  - Saturating counters, cleared by reset.
  - Incremented on each gnt and each err valid respectively.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP, ERR)
  - port-id constants PORT_F=0, PORT_D=1
  - default ADDR_LIMIT/MEM_LAT constants
- Sub-module rr_arb2 holds the two-requester round-robin pick plus pointer register, with inputs req[1:0] and advance and output grant[1:0].

Test Plan:
- D read, MEM_LAT=2: preload word 5 = 0xDEAD_BEEF; d_req with d_addr=5 -> d_gnt at T, m_en at T+1, d_valid at T+4 with d_rdata=0xDEAD_BEEF, d_err=0.
- D write then F read: write 0x1234 to addr 1023, then f_addr=1023 -> write valid with d_err=0; f_rdata=0x1234.
- Range error: d_addr=1024, and separately d_addr=64'h1_0000_0005 -> d_valid at T+1 with d_err=1, m_en never asserted, memory unchanged.
- Contention: f_req and d_req held high from reset for 4 transactions -> grant order F,D,F,D; no overlapping gnt or valid.
- Async reset in WAIT: drop reset_n -> m_en, busy and valids go to 0 immediately; after release, a new F read to addr 0 completes normally.
- With MEM_PORT_ARBITER_STATS_EN: 3 F grants, 2 D grants and 1 error -> f_gnt_cnt=3, d_gnt_cnt=2, err_cnt=1.
